// File: rtl/gray2bin_seq_conv.sv
// Bit-serial Gray-to-binary decoder: a start strobe captures a Gray word, one
// binary bit is resolved per cycle MSB first, and done pulses with the result.
module gray2bin_seq_conv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] gray_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] bin_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONVERT  = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] gray_reg_r;
    logic [WIDTH-1:0] gray_reg_s;
    logic [WIDTH-1:0] work_reg_r;
    logic [WIDTH-1:0] work_reg_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic [WIDTH-1:0] bin_out_r;
    logic [WIDTH-1:0] bin_out_s;

    // Resolved bit for the current position; work_up_s[i] is the already
    // resolved neighbour work_reg_r[i+1].
    logic [WIDTH-1:0] work_up_s;
    logic             res_bit_s;

    assign work_up_s = {1'b0, work_reg_r[WIDTH-1:1]};

    // Select the binary bit being resolved this cycle.
    always_comb begin
        res_bit_s = 1'b0;
        if (cnt_r == CNT_MAX) begin
            res_bit_s = gray_reg_r[cnt_r];
        end else begin
            res_bit_s = work_up_s[cnt_r] ^ gray_reg_r[cnt_r];
        end
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_s    = state_r;
        gray_reg_s = gray_reg_r;
        work_reg_s = work_reg_r;
        cnt_s      = cnt_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        bin_out_s  = bin_out_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    gray_reg_s = gray_in;
                    work_reg_s = {WIDTH{1'b0}};
                    cnt_s      = CNT_MAX;
                    busy_s     = 1'b1;
                    state_s    = ST_CONVERT;
                end else begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                busy_s            = 1'b1;
                work_reg_s[cnt_r] = res_bit_s;
                if (cnt_r == CNT_ZERO) begin
                    // Bit 0 lands in the same edge that publishes the word.
                    bin_out_s = work_reg_s;
                    done_s    = 1'b1;
                    state_s   = ST_COMPLETE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                    state_s = ST_CONVERT;
                end
            end
            ST_COMPLETE: begin
                busy_s  = 1'b0;
                done_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                done_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gray_reg_r <= {WIDTH{1'b0}};
            work_reg_r <= {WIDTH{1'b0}};
            cnt_r      <= CNT_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bin_out_r  <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            gray_reg_r <= gray_reg_s;
            work_reg_r <= work_reg_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            bin_out_r  <= bin_out_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bin_out = bin_out_r;

endmodule

// File: tb/tb_gray2bin_seq_conv.sv
// Directed plus randomized bench for gray2bin_seq_conv (WIDTH=8 and WIDTH=2),
// checked against an XOR-of-shifts reference model.
module tb_gray2bin_seq_conv;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] gray_in;
    logic       busy;
    logic       done;
    logic [7:0] bin_out;
    logic       start2;
    logic [1:0] gray2;
    logic       busy2;
    logic       done2;
    logic [1:0] bin2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray2bin_seq_conv #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gray_in(gray_in),
        .busy(busy), .done(done), .bin_out(bin_out)
    );

    gray2bin_seq_conv #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .gray_in(gray2),
        .busy(busy2), .done(done2), .bin_out(bin2)
    );

    // Binary value of a Gray word: XOR of the word with all its right shifts.
    function automatic logic [31:0] ref_bin(input logic [31:0] g, input int w);
        logic [31:0] acc;
        acc = 32'd0;
        for (int s = 0; s < w; s++) acc = acc ^ (g >> s);
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge of the first idle cycle.
    task automatic run_conv(input logic [7:0] g, input logic [7:0] exp, input string tag);
        int   cyc;
        int   busy_cycles;
        logic [7:0] prev;
        logic held;
        start   = 1'b1;
        gray_in = g;
        @(negedge clk);
        start   = 1'b0;
        gray_in = 8'($urandom);
        prev = bin_out;
        held = 1'b1;
        cyc  = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && cyc < 30) begin
            if (busy === 1'b1) busy_cycles++;
            if (bin_out !== prev) held = 1'b0;
            @(negedge clk);
            cyc++;
            gray_in = 8'($urandom);
        end
        if (busy === 1'b1) busy_cycles++;
        check({tag, "_latency"}, 32'(cyc), 32'd9);
        check({tag, "_bin"}, {24'd0, bin_out}, {24'd0, exp});
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
        check({tag, "_hold"}, {31'd0, held}, 32'd1);
        @(negedge clk);
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         cyc;
        logic [7:0] cap;
        logic [7:0] g;
        rst_n   = 1'b0;
        start   = 1'b0;
        gray_in = 8'd0;
        start2  = 1'b0;
        gray2   = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bin", {24'd0, bin_out}, 32'd0);
        check("rst_busy2", {31'd0, busy2}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_conv(8'hC0, 8'h80, "c0");
        run_conv(8'hFF, 8'hAA, "ff");
        run_conv(8'h1A, 8'h13, "1a");
        run_conv(8'h00, 8'h00, "zero");

        // WIDTH=2 instance
        start2 = 1'b1;
        gray2  = 2'b11;
        @(negedge clk);
        start2 = 1'b0;
        gray2  = 2'b00;
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w2_latency", 32'(cyc), 32'd3);
        check("w2_bin", {30'd0, bin2}, 32'd2);
        @(negedge clk);
        check("w2_done_width", {31'd0, done2}, 32'd0);

        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), 8'(ref_bin(32'(v), 8)), "sweep");
        end

        for (int r = 0; r < 16; r++) begin
            g = 8'($urandom);
            run_conv(g, 8'(ref_bin({24'd0, g}, 8)), "rand");
        end

        // start held high, gray_in toggling every cycle
        start   = 1'b1;
        gray_in = 8'($urandom);
        cap     = gray_in;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("cont_busy", {31'd0, busy}, 32'd1);
            repeat (8) begin
                gray_in = 8'($urandom);
                @(negedge clk);
            end
            check("cont_done", {31'd0, done}, 32'd1);
            check("cont_bin", {24'd0, bin_out}, ref_bin({24'd0, cap}, 8));
            gray_in = 8'($urandom);
            @(negedge clk);
            check("cont_idle_done", {31'd0, done}, 32'd0);
            check("cont_idle_busy", {31'd0, busy}, 32'd0);
            if (j == 3) start = 1'b0;
            gray_in = 8'($urandom);
            cap     = gray_in;
        end
        @(negedge clk);
        check("cont_stop", {31'd0, busy}, 32'd0);

        // asynchronous reset in the 4th CONVERT cycle
        run_conv(8'hFF, 8'hAA, "pre_rst");
        start   = 1'b1;
        gray_in = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_bin", {24'd0, bin_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv(8'h1A, 8'h13, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
